// File: rtl/fetch_pc_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pc_sequencer_pkg
//  Shared definitions for the instruction-fetch stage.
//  - Default widths and the reset PC used by fetch_pc_sequencer.
//  - Encoding of the fetch FSM, also visible on the top-level debug port.
// ----------------------------------------------------------------------------
package fetch_pc_sequencer_pkg;

   localparam int          ADDR_W_DEF   = 32;
   localparam int          INSTR_W_DEF  = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   // S_BOOT : one idle cycle after reset release, no request issued
   // S_FETCH: request outstanding at PC
   // S_HOLD : word returned while IF/ID was stalled, parked in hold buffer
   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } fetchState_t;

endpackage

// File: rtl/fetch_pc_sequencer_if_id_reg.sv
// ----------------------------------------------------------------------------
// fetch_pc_sequencer_if_id_reg
//  IF/ID pipeline register: instruction word, its PC and a valid bit.
//  Priority per cycle: flush > load > (hold if stalled, else drain).
// Ports
//  inClk, inRstN  clock, asynchronous active-low reset
//  inFlush        redirect in progress: clear valid, even when stalled
//  inLoad         capture inInstr/inPc and mark valid
//  inStall        downstream not consuming: keep current contents
//  inInstr, inPc  data to capture on inLoad
//  outInstr, outPc, outValid  register contents
// ----------------------------------------------------------------------------
module fetch_pc_sequencer_if_id_reg #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               inClk,
   input  logic               inRstN,
   input  logic               inFlush,
   input  logic               inLoad,
   input  logic               inStall,
   input  logic [INSTR_W-1:0] inInstr,
   input  logic [ADDR_W-1:0]  inPc,
   output logic [INSTR_W-1:0] outInstr,
   output logic [ADDR_W-1:0]  outPc,
   output logic               outValid
);

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         outInstr <= '0;
         outPc    <= '0;
         outValid <= 1'b0;
      end else if (inFlush) begin
         // Data fields are left as-is; only valid matters after a flush.
         outValid <= 1'b0;
      end else if (inLoad) begin
         outInstr <= inInstr;
         outPc    <= inPc;
         outValid <= 1'b1;
      end else if (!inStall) begin
         // Consumer took the entry and nothing new arrived.
         outValid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_pc_sequencer
//  Sequential instruction-fetch stage. Owns the PC, issues one word fetch at a
//  time to instruction memory, fills the IF/ID register and exposes PC+4 for
//  the jump-target unit. Jump and taken-branch redirects flush IF/ID and
//  cancel any fetch in flight.
// Ports
//  inClk, inRstN      clock, asynchronous active-low reset
//  inStall            ID hazard: IF/ID must hold its contents
//  inJumpValid/Target 1-cycle jump redirect
//  inBranchValid/Target 1-cycle taken-branch redirect (wins over jump)
//  outImemReq/Addr    fetch request and address (address = PC)
//  inImemValid/Data   memory response
//  outPostPc          PC+4 (combinational, wraps)
//  outInstr/outIfPc/outInstrValid  IF/ID contents
//  outDbgState        current fetch FSM state (fetchState_t encoding)
//
// Memory handshake: outImemReq rises with outImemAddr valid and stays high
// until the cycle inImemValid is seen (at least one cycle later); that cycle
// completes the request. If outImemReq is still high the next cycle, that is a
// new request at the then-current address. A redirect while a request is in
// flight moves the PC immediately; the in-flight response still arrives and is
// thrown away (discard), after which the fetch restarts at the new PC.
// ----------------------------------------------------------------------------
module fetch_pc_sequencer
   import fetch_pc_sequencer_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic               inClk,
   input  logic               inRstN,
   input  logic               inStall,
   input  logic               inJumpValid,
   input  logic [ADDR_W-1:0]  inJumpTarget,
   input  logic               inBranchValid,
   input  logic [ADDR_W-1:0]  inBranchTarget,
   output logic               outImemReq,
   output logic [ADDR_W-1:0]  outImemAddr,
   input  logic               inImemValid,
   input  logic [INSTR_W-1:0] inImemData,
   output logic [ADDR_W-1:0]  outPostPc,
   output logic [INSTR_W-1:0] outInstr,
   output logic [ADDR_W-1:0]  outIfPc,
   output logic               outInstrValid,
   output logic [1:0]         outDbgState
);

   fetchState_t        state;
   logic [ADDR_W-1:0]  pc;
   logic               discard;
   logic [INSTR_W-1:0] holdBuf;

   logic               redirect;
   logic [ADDR_W-1:0]  redirTarget;
   logic [ADDR_W-1:0]  redirPc;
   logic [ADDR_W-1:0]  incPc;
   logic               ifIdFree;
   logic               loadFromMem;
   logic               loadFromHold;
   logic               ifLoad;
   logic [INSTR_W-1:0] ifInstr;

   always_comb begin
      // Redirects are ignored during the boot cycle.
      redirect     = (inBranchValid || inJumpValid) && (state != S_BOOT);
      // Branch is the older instruction, so it takes precedence.
      redirTarget  = inBranchValid ? inBranchTarget : inJumpTarget;
      redirPc      = redirTarget & ~ADDR_W'(3);
      incPc        = pc + ADDR_W'(4);
      ifIdFree     = !outInstrValid || !inStall;
      loadFromMem  = !redirect && (state == S_FETCH) && inImemValid && !discard && ifIdFree;
      loadFromHold = !redirect && (state == S_HOLD) && !inStall;
      ifLoad       = loadFromMem || loadFromHold;
      ifInstr      = loadFromHold ? holdBuf : inImemData;
   end

   assign outImemAddr = pc;
   assign outPostPc   = incPc;
   assign outDbgState = state;

   // Fetch FSM. outImemReq is registered alongside the state so it is high
   // exactly in S_FETCH.
   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         state      <= S_BOOT;
         pc         <= RESET_PC;
         discard    <= 1'b0;
         holdBuf    <= '0;
         outImemReq <= 1'b0;
      end else begin
         case (state)
            S_BOOT: begin
               state      <= S_FETCH;
               outImemReq <= 1'b1;
            end

            S_FETCH: begin
               if (redirect) begin
                  pc         <= redirPc;
                  // A response arriving this same cycle closes the old request,
                  // so nothing remains to be discarded.
                  discard    <= !inImemValid;
                  outImemReq <= 1'b1;
               end else if (inImemValid) begin
                  if (discard) begin
                     // Stale response: drop it and fetch again at PC.
                     discard    <= 1'b0;
                     outImemReq <= 1'b1;
                  end else if (ifIdFree) begin
                     pc         <= incPc;
                     outImemReq <= 1'b1;
                  end else begin
                     holdBuf    <= inImemData;
                     state      <= S_HOLD;
                     outImemReq <= 1'b0;
                  end
               end
            end

            S_HOLD: begin
               // PC still names the buffered word until it moves into IF/ID.
               if (redirect) begin
                  pc         <= redirPc;
                  state      <= S_FETCH;
                  outImemReq <= 1'b1;
               end else if (!inStall) begin
                  pc         <= incPc;
                  state      <= S_FETCH;
                  outImemReq <= 1'b1;
               end
            end

            default: begin
               state      <= S_BOOT;
               outImemReq <= 1'b0;
            end
         endcase
      end
   end

   fetch_pc_sequencer_if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) uIfId (
      .inClk    (inClk),
      .inRstN   (inRstN),
      .inFlush  (redirect),
      .inLoad   (ifLoad),
      .inStall  (inStall),
      .inInstr  (ifInstr),
      .inPc     (pc),
      .outInstr (outInstr),
      .outPc    (outIfPc),
      .outValid (outInstrValid)
   );

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_pc_sequencer
//  Bench for fetch_pc_sequencer: clock/reset, a behavioural instruction
//  memory with configurable latency, directed scenario tasks and a randomized
//  run checked against a program-order model of the fetched stream.
// ----------------------------------------------------------------------------
module tb_fetch_pc_sequencer;
   import fetch_pc_sequencer_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0000;

   // ---------------- clock / reset ----------------
   logic inClk = 1'b0;
   logic inRstN = 1'b0;
   always #5 inClk = ~inClk;

   // ---------------- DUT signals ----------------
   logic        inStall = 1'b0;
   logic        inJumpValid = 1'b0;
   logic [31:0] inJumpTarget = '0;
   logic        inBranchValid = 1'b0;
   logic [31:0] inBranchTarget = '0;
   logic        outImemReq;
   logic [31:0] outImemAddr;
   logic        inImemValid;
   logic [31:0] inImemData;
   logic [31:0] outPostPc;
   logic [31:0] outInstr;
   logic [31:0] outIfPc;
   logic        outInstrValid;
   logic [1:0]  outDbgState;

   // Memory model outputs and a manual override for injecting stray responses.
   logic        memValid = 1'b0;
   logic [31:0] memData = '0;
   logic        forceValid = 1'b0;
   logic [31:0] forceData = '0;
   assign inImemValid = memValid | forceValid;
   assign inImemData  = forceValid ? forceData : memData;

   int memLatency = 1;
   bit randMode = 1'b0;
   bit memBusy = 1'b0;
   int memCnt = 0;
   logic [31:0] memAddr = '0;

   int testsRun = 0;
   int testsFailed = 0;

   fetch_pc_sequencer dut (
      .inClk          (inClk),
      .inRstN         (inRstN),
      .inStall        (inStall),
      .inJumpValid    (inJumpValid),
      .inJumpTarget   (inJumpTarget),
      .inBranchValid  (inBranchValid),
      .inBranchTarget (inBranchTarget),
      .outImemReq     (outImemReq),
      .outImemAddr    (outImemAddr),
      .inImemValid    (inImemValid),
      .inImemData     (inImemData),
      .outPostPc      (outPostPc),
      .outInstr       (outInstr),
      .outIfPc        (outIfPc),
      .outInstrValid  (outInstrValid),
      .outDbgState    (outDbgState)
   );

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   // Memory: latches the address when a request is seen while idle, answers
   // after the latency with a one-cycle valid pulse.
   initial begin : memModel
      forever begin
         @(posedge inClk);
         #1;
         if (!inRstN) begin
            memBusy  = 1'b0;
            memValid = 1'b0;
         end else begin
            if (memValid) begin
               memValid = 1'b0;
               memBusy  = 1'b0;
            end else if (memBusy) begin
               memCnt = memCnt - 1;
               if (memCnt <= 0) begin
                  memValid = 1'b1;
                  memData  = memWord(memAddr);
               end
            end
            if (!memBusy && outImemReq) begin
               memBusy = 1'b1;
               memCnt  = randMode ? int'($urandom_range(1, 4)) : memLatency;
               memAddr = outImemAddr;
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge inClk);
      #1;
   endtask

   // Leaves the DUT in its S_BOOT cycle.
   task automatic doReset();
      inStall       = 1'b0;
      inJumpValid   = 1'b0;
      inBranchValid = 1'b0;
      forceValid    = 1'b0;
      randMode      = 1'b0;
      inRstN        = 1'b0;
      repeat (2) tick();
      inRstN = 1'b1;
   endtask

   // Advance until IF/ID is consumed (valid and not stalled) or budget expires.
   task automatic waitConsume(input int budget, output bit ok,
                              output logic [31:0] pc, output logic [31:0] instr);
      ok = 1'b0;
      pc = '0;
      instr = '0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (outInstrValid && !inStall) begin
            ok = 1'b1;
            pc = outIfPc;
            instr = outInstr;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) tick();
      testsRun++; if (outImemReq !== 1'b0) begin testsFailed++; $display("FAIL reset_req: got %0b want 0", outImemReq); end
      testsRun++; if (outInstrValid !== 1'b0) begin testsFailed++; $display("FAIL reset_valid: got %0b want 0", outInstrValid); end
      testsRun++; if (outInstr !== 32'h0) begin testsFailed++; $display("FAIL reset_instr: got %h want 0", outInstr); end
      testsRun++; if (outIfPc !== 32'h0) begin testsFailed++; $display("FAIL reset_ifpc: got %h want 0", outIfPc); end
      testsRun++; if (outImemAddr !== RPC) begin testsFailed++; $display("FAIL reset_addr: got %h want %h", outImemAddr, RPC); end
      testsRun++; if (outPostPc !== RPC + 32'd4) begin testsFailed++; $display("FAIL reset_postpc: got %h want %h", outPostPc, RPC + 32'd4); end
      inRstN = 1'b1;
      testsRun++; if (outImemReq !== 1'b0) begin testsFailed++; $display("FAIL boot_req: got %0b want 0", outImemReq); end
      tick();
      testsRun++; if (outImemReq !== 1'b1 || outImemAddr !== RPC) begin testsFailed++; $display("FAIL first_req: got req=%0b addr=%h want 1/%h", outImemReq, outImemAddr, RPC); end
   endtask

   task automatic test_sequential();
      logic [31:0] expQ[$];
      logic [31:0] exp;
      logic [31:0] pc;
      logic [31:0] ins;
      bit ok;
      doReset();
      memLatency = 1;
      tick();
      testsRun++; if (outImemAddr !== 32'h0 || outPostPc !== 32'h4) begin testsFailed++; $display("FAIL seq_postpc: got addr=%h post=%h want 0/4", outImemAddr, outPostPc); end
      expQ.push_back(32'h0);
      expQ.push_back(32'h4);
      expQ.push_back(32'h8);
      while (expQ.size() > 0) begin
         exp = expQ.pop_front();
         waitConsume(20, ok, pc, ins);
         testsRun++;
         if (!ok) begin testsFailed++; $display("FAIL seq_timeout: got none want pc %h", exp); end
         else begin
            if (pc !== exp) begin testsFailed++; $display("FAIL seq_pc: got %h want %h", pc, exp); end
            testsRun++; if (ins !== memWord(exp)) begin testsFailed++; $display("FAIL seq_instr: got %h want %h", ins, memWord(exp)); end
         end
      end
   endtask

   task automatic test_stall_hold();
      bit found;
      doReset();
      memLatency = 1;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (outInstrValid && outIfPc == 32'h4) begin found = 1'b1; break; end
      end
      testsRun++; if (!found) begin testsFailed++; $display("FAIL stall_setup: got no pc 4 want pc 4 in IF/ID"); end
      inStall = 1'b1;
      tick();
      tick();
      testsRun++; if (outDbgState !== S_HOLD) begin testsFailed++; $display("FAIL stall_state: got %0d want %0d", outDbgState, S_HOLD); end
      testsRun++; if (outImemReq !== 1'b0) begin testsFailed++; $display("FAIL stall_req: got %0b want 0", outImemReq); end
      testsRun++; if (outIfPc !== 32'h4 || outInstrValid !== 1'b1) begin testsFailed++; $display("FAIL stall_ifid: got pc=%h v=%0b want 4/1", outIfPc, outInstrValid); end
      tick();
      inStall = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (outInstrValid && outIfPc == 32'h8) begin found = 1'b1; break; end
      end
      testsRun++;
      if (!found) begin testsFailed++; $display("FAIL stall_release: got no pc 8 want pc 8 in IF/ID"); end
      else begin
         testsRun++; if (outInstr !== memWord(32'h8)) begin testsFailed++; $display("FAIL stall_instr: got %h want %h", outInstr, memWord(32'h8)); end
         testsRun++; if (outImemReq !== 1'b1 || outImemAddr !== 32'hC) begin testsFailed++; $display("FAIL stall_nextreq: got req=%0b addr=%h want 1/c", outImemReq, outImemAddr); end
      end
   endtask

   task automatic test_jump();
      bit found;
      bit ok;
      logic [31:0] pc;
      logic [31:0] ins;
      doReset();
      memLatency = 3;
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (outInstrValid) begin found = 1'b1; break; end
      end
      testsRun++; if (!found || outIfPc !== 32'h0) begin testsFailed++; $display("FAIL jump_setup: got found=%0b pc=%h want 1/0", found, outIfPc); end
      // Request for 0x4 is now in flight; jump while IF/ID is stalled.
      inStall      = 1'b1;
      inJumpValid  = 1'b1;
      inJumpTarget = 32'h0040_0010;
      tick();
      inJumpValid = 1'b0;
      testsRun++; if (outInstrValid !== 1'b0) begin testsFailed++; $display("FAIL jump_flush: got %0b want 0", outInstrValid); end
      testsRun++; if (outImemReq !== 1'b1 || outImemAddr !== 32'h0040_0010) begin testsFailed++; $display("FAIL jump_addr: got req=%0b addr=%h want 1/00400010", outImemReq, outImemAddr); end
      inStall = 1'b0;
      waitConsume(30, ok, pc, ins);
      testsRun++;
      if (!ok) begin testsFailed++; $display("FAIL jump_timeout: got none want pc 00400010"); end
      else begin
         if (pc !== 32'h0040_0010) begin testsFailed++; $display("FAIL jump_pc: got %h want 00400010", pc); end
         testsRun++; if (ins !== memWord(32'h0040_0010)) begin testsFailed++; $display("FAIL jump_instr: got %h want %h", ins, memWord(32'h0040_0010)); end
      end
   endtask

   task automatic test_back_to_back_redirect();
      bit ok;
      logic [31:0] pc;
      logic [31:0] ins;
      doReset();
      memLatency = 1;
      waitConsume(20, ok, pc, ins);
      inBranchValid  = 1'b1;
      inBranchTarget = 32'h100;
      inJumpValid    = 1'b1;
      inJumpTarget   = 32'h200;
      tick();
      inBranchValid = 1'b0;
      inJumpValid   = 1'b0;
      testsRun++; if (outImemAddr !== 32'h100) begin testsFailed++; $display("FAIL both_addr: got %h want 100", outImemAddr); end
      waitConsume(20, ok, pc, ins);
      testsRun++; if (!ok || pc !== 32'h100) begin testsFailed++; $display("FAIL both_pc: got ok=%0b pc=%h want 1/100", ok, pc); end
   endtask

   task automatic test_align_wrap();
      bit ok;
      logic [31:0] pc;
      logic [31:0] ins;
      inBranchValid  = 1'b1;
      inBranchTarget = 32'h103;
      tick();
      inBranchValid = 1'b0;
      testsRun++; if (outImemAddr !== 32'h100) begin testsFailed++; $display("FAIL align_addr: got %h want 100", outImemAddr); end
      waitConsume(20, ok, pc, ins);
      testsRun++; if (!ok || pc !== 32'h100 || ins !== memWord(32'h100)) begin testsFailed++; $display("FAIL align_pc: got ok=%0b pc=%h ins=%h want 1/100/%h", ok, pc, ins, memWord(32'h100)); end
      inBranchValid  = 1'b1;
      inBranchTarget = 32'hFFFF_FFF8;
      tick();
      inBranchValid = 1'b0;
      waitConsume(20, ok, pc, ins);
      testsRun++; if (!ok || pc !== 32'hFFFF_FFF8) begin testsFailed++; $display("FAIL wrap_pc0: got ok=%0b pc=%h want 1/fffffff8", ok, pc); end
      testsRun++; if (outImemAddr !== 32'hFFFF_FFFC || outPostPc !== 32'h0) begin testsFailed++; $display("FAIL wrap_postpc: got addr=%h post=%h want fffffffc/0", outImemAddr, outPostPc); end
      waitConsume(20, ok, pc, ins);
      testsRun++; if (!ok || pc !== 32'hFFFF_FFFC || ins !== memWord(32'hFFFF_FFFC)) begin testsFailed++; $display("FAIL wrap_pc1: got ok=%0b pc=%h want 1/fffffffc", ok, pc); end
      testsRun++; if (outImemAddr !== 32'h0) begin testsFailed++; $display("FAIL wrap_addr: got %h want 0", outImemAddr); end
      waitConsume(20, ok, pc, ins);
      testsRun++; if (!ok || pc !== 32'h0) begin testsFailed++; $display("FAIL wrap_pc2: got ok=%0b pc=%h want 1/0", ok, pc); end
   endtask

   task automatic test_reset_midfetch();
      bit ok;
      logic [31:0] pc;
      logic [31:0] ins;
      doReset();
      memLatency = 3;
      waitConsume(30, ok, pc, ins);
      waitConsume(30, ok, pc, ins);
      testsRun++; if (!ok || pc !== 32'h4) begin testsFailed++; $display("FAIL rstmid_setup: got ok=%0b pc=%h want 1/4", ok, pc); end
      #1;
      inRstN = 1'b0;
      #1;
      testsRun++; if (outImemReq !== 1'b0 || outInstrValid !== 1'b0) begin testsFailed++; $display("FAIL rstmid_clear: got req=%0b v=%0b want 0/0", outImemReq, outInstrValid); end
      testsRun++; if (outImemAddr !== RPC || outIfPc !== 32'h0) begin testsFailed++; $display("FAIL rstmid_pc: got addr=%h ifpc=%h want %h/0", outImemAddr, outIfPc, RPC); end
      repeat (2) tick();
      inRstN     = 1'b1;
      forceValid = 1'b1;
      forceData  = 32'hDEAD_BEEF;
      tick();
      forceValid = 1'b0;
      testsRun++; if (outImemReq !== 1'b1 || outImemAddr !== RPC || outInstrValid !== 1'b0) begin testsFailed++; $display("FAIL rstmid_boot: got req=%0b addr=%h v=%0b want 1/%h/0", outImemReq, outImemAddr, outInstrValid, RPC); end
      waitConsume(30, ok, pc, ins);
      testsRun++; if (!ok || pc !== RPC || ins !== memWord(RPC)) begin testsFailed++; $display("FAIL rstmid_first: got ok=%0b pc=%h ins=%h want 1/%h/%h", ok, pc, ins, RPC, memWord(RPC)); end
   endtask

   // Program-order model: every consumed IF/ID entry must be the next address
   // of the stream; a redirect restarts the stream at its aligned target.
   task automatic test_random();
      logic [31:0] expNext;
      logic [31:0] tgt;
      int consumed;
      doReset();
      randMode = 1'b1;
      expNext = RPC;
      consumed = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         inBranchValid = 1'b0;
         inJumpValid   = 1'b0;
         inStall       = ($urandom_range(0, 99) < 30);
         if (outInstrValid && !inStall) begin
            consumed++;
            testsRun++; if (outIfPc !== expNext) begin testsFailed++; $display("FAIL rand_pc: got %h want %h", outIfPc, expNext); end
            testsRun++; if (outInstr !== memWord(expNext)) begin testsFailed++; $display("FAIL rand_instr: got %h want %h", outInstr, memWord(expNext)); end
            expNext = expNext + 32'd4;
         end
         if (outImemReq) begin
            testsRun++; if (outPostPc !== outImemAddr + 32'd4) begin testsFailed++; $display("FAIL rand_postpc: got %h want %h", outPostPc, outImemAddr + 32'd4); end
         end
         if (cyc > 4 && $urandom_range(0, 99) < 4) begin
            tgt = $urandom;
            case ($urandom_range(0, 2))
               0: begin inBranchValid = 1'b1; inBranchTarget = tgt; end
               1: begin inJumpValid = 1'b1; inJumpTarget = tgt; end
               default: begin
                  inBranchValid = 1'b1; inBranchTarget = tgt;
                  inJumpValid = 1'b1; inJumpTarget = $urandom;
               end
            endcase
            expNext = tgt & 32'hFFFF_FFFC;
         end
      end
      tick();
      inBranchValid = 1'b0;
      inJumpValid   = 1'b0;
      inStall       = 1'b0;
      randMode      = 1'b0;
      testsRun++; if (consumed < 200) begin testsFailed++; $display("FAIL rand_progress: got %0d want >= 200", consumed); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_sequential();
      test_stall_hold();
      test_jump();
      test_back_to_back_redirect();
      test_align_wrap();
      test_reset_midfetch();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
